// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: decode-to-execute stage with load-use hazard detection and a two-entry head/skid buffer.
module id_ex_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rega,
  input  logic [DATA_W-1:0] in_regb,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  input  logic              stop_debug,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rega,
  output logic [DATA_W-1:0] out_regb,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_jaddr,
  output logic [5:0]        out_opcode,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  // Only instr[31:11] is needed downstream; the immediate is already expanded at push.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] jaddr;
    logic [20:0]       fields;
  } entry_t;
  entry_t head, skid, in_e;
  logic head_valid, skid_valid, hazard, push, pop;
  logic [5:0] op;
  logic [15:0] imm16;
  logic [REG_AW-1:0] in_rs, in_rt;
  always_comb begin
    op = in_instr[31:26];
    imm16 = in_instr[15:0];
    in_rs = REG_AW'(in_instr[25:21]);
    in_rt = REG_AW'(in_instr[20:16]);
    in_e.ctrl = in_ctrl;
    in_e.pc = in_pc;
    in_e.rega = in_rega;
    in_e.regb = in_regb;
    in_e.imm = (op >= 6'd12 && op <= 6'd14) ? DATA_W'(imm16) :
               (op == 6'd15) ? DATA_W'({imm16, 16'h0000}) :
               {{(DATA_W-16){imm16[15]}}, imm16};
    in_e.jaddr = {in_pc[DATA_W-1:28], in_instr[25:0], 2'b00};
    in_e.fields = in_instr[31:11];
  end
  assign hazard = in_valid & ex_mem_read & (ex_rd != '0) & (ex_rd == in_rs | ex_rd == in_rt);
  assign hazard_stall = hazard;
  assign in_ready = rst & ~stop_debug & ~flush & ~hazard & ~skid_valid;
  assign out_valid = head_valid & ~stop_debug;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head <= '0;
      skid <= '0;
      instr_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      head_valid <= ~flush & (push | (head_valid & ~(pop & ~skid_valid)));
      skid_valid <= ~flush & ((push & head_valid & ~pop) | (skid_valid & ~pop));
      if (pop & skid_valid) head <= skid;
      else if (push & (~head_valid | pop)) head <= in_e;
      if (push & head_valid & ~pop) skid <= in_e;
      instr_cnt <= instr_cnt + CNT_W'(pop & ~&instr_cnt);
      bubble_cnt <= bubble_cnt + CNT_W'(hazard & ~stop_debug & ~&bubble_cnt);
    end
  end
  assign out_ctrl = head.ctrl;
  assign out_pc = head.pc;
  assign out_rega = head.rega;
  assign out_regb = head.regb;
  assign out_imm = head.imm;
  assign out_jaddr = head.jaddr;
  assign out_opcode = head.fields[20:15];
  assign out_rs = REG_AW'(head.fields[14:10]);
  assign out_rt = REG_AW'(head.fields[9:5]);
  assign out_rd = REG_AW'(head.fields[4:0]);
endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb_id_ex_stage_buf: directed plus random stimulus checked against a queue-based model of the stage.
module tb_id_ex_stage_buf;
  localparam int CW = 5;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst = 0, in_valid = 0, in_ready, ex_mem_read = 0, flush = 0, stop_debug = 0;
  logic out_valid, out_ready = 0, hazard_stall;
  logic [31:0] in_pc = 0, in_instr = 0, in_rega = 0, in_regb = 0;
  logic [14:0] in_ctrl = 0, out_ctrl;
  logic [4:0] ex_rd = 0, out_rs, out_rt, out_rd;
  logic [31:0] out_pc, out_rega, out_regb, out_imm, out_jaddr;
  logic [5:0] out_opcode;
  logic [CW-1:0] instr_cnt, bubble_cnt;
  int total = 0, bad = 0, icnt = 0, bcnt = 0;
  typedef struct {
    logic [14:0] ctrl;
    logic [31:0] pc, ra, rb, instr;
  } ent_t;
  ent_t q[$];

  id_ex_stage_buf #(.DATA_W(32), .REG_AW(5), .CTRL_W(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .in_ctrl(in_ctrl), .in_rega(in_rega), .in_regb(in_regb),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush), .stop_debug(stop_debug),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
    .out_rega(out_rega), .out_regb(out_regb), .out_imm(out_imm), .out_jaddr(out_jaddr),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .hazard_stall(hazard_stall), .instr_cnt(instr_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    int op;
    logic [15:0] i;
    op = int'(ins[31:26]);
    i = ins[15:0];
    if (op >= 12 && op <= 14) return {16'h0000, i};
    if (op == 15) return {i, 16'h0000};
    return {{16{i[15]}}, i};
  endfunction

  // One clock: apply inputs, check combinational and head outputs before the edge, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy,
                      input logic fl, input logic sd, input logic mr, input logic [4:0] erd);
    logic hz, rdy, ov;
    ent_t e;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; stop_debug = sd;
    ex_mem_read = mr; ex_rd = erd;
    in_ctrl = 15'($urandom); in_rega = $urandom; in_regb = $urandom;
    e = '{ctrl: in_ctrl, pc: pc, ra: in_rega, rb: in_regb, instr: ins};
    @(negedge clk);
    hz = v && mr && erd != 0 && (erd == ins[25:21] || erd == ins[20:16]);
    rdy = !sd && !fl && !hz && q.size() < 2;
    ov = q.size() > 0 && !sd;
    chk("hazard_stall", hazard_stall, hz);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, ov);
    chk("instr_cnt", instr_cnt, icnt);
    chk("bubble_cnt", bubble_cnt, bcnt);
    if (q.size() > 0) begin
      chk("out_ctrl", out_ctrl, q[0].ctrl);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_rega", out_rega, q[0].ra);
      chk("out_regb", out_regb, q[0].rb);
      chk("out_imm", out_imm, exp_imm(q[0].instr));
      chk("out_jaddr", out_jaddr, {q[0].pc[31:28], q[0].instr[25:0], 2'b00});
      chk("out_opcode", out_opcode, q[0].instr[31:26]);
      chk("out_rs", out_rs, q[0].instr[25:21]);
      chk("out_rt", out_rt, q[0].instr[20:16]);
      chk("out_rd", out_rd, q[0].instr[15:11]);
    end
    @(posedge clk);
    if (ov && ordy) begin
      void'(q.pop_front());
      if (icnt < MAXC) icnt++;
    end
    if (hz && !sd && bcnt < MAXC) bcnt++;
    if (fl) q.delete();
    if (v && rdy) q.push_back(e);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
    chk("rst_out_imm", out_imm, 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    // addi r1,r0,-5 then ori, lui, j with streaming pops
    step(1, 32'h2001FFFB, 32'h0000_1004, 1, 0, 0, 0, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_rt", out_rt, 1);
    step(1, 32'h3401FFFF, 32'h0000_1008, 1, 0, 0, 0, 0);
    chk("ori_imm", out_imm, 32'h0000FFFF);
    chk("addi_cnt", instr_cnt, 1);
    step(1, 32'h3C011234, 32'h0000_100C, 1, 0, 0, 0, 0);
    chk("lui_imm", out_imm, 32'h12340000);
    step(1, 32'h08000010, 32'h40000004, 1, 0, 0, 0, 0);
    chk("j_jaddr", out_jaddr, 32'h40000040);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // load-use: rs=3 against a load into r3 for three cycles, then ex_rd=0
    for (int i = 0; i < 3; i++) step(1, 32'h20610005, 32'h2004, 1, 0, 0, 1, 3);
    chk("load_use_bubbles", bubble_cnt, 3);
    step(1, 32'h20610005, 32'h2004, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // back-pressure: fill, offer a third, then drain in order
    step(1, 32'h20020001, 32'h3004, 0, 0, 0, 0, 0);
    step(1, 32'h20030002, 32'h3008, 0, 0, 0, 0, 0);
    chk("full_in_ready", in_ready, 0);
    step(1, 32'h20040003, 32'h300C, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("drain_b_pc", out_pc, 32'h3008);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    // flush with two entries and an offered beat
    step(1, 32'h20050004, 32'h4004, 0, 0, 0, 0, 0);
    step(1, 32'h20060005, 32'h4008, 0, 0, 0, 0, 0);
    step(1, 32'h20070006, 32'h400C, 0, 1, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    // debug freeze holds contents and counters
    step(1, 32'h20080007, 32'h5004, 0, 0, 0, 0, 0);
    step(1, 32'h20090008, 32'h5008, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h200A0009, 32'h500C, 1, 0, 1, 1, 10);
    chk("freeze_cnt", instr_cnt, icnt);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 3)));
      if (i == 200) begin
        rst = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_instr_cnt", instr_cnt, 0);
        chk("arst_bubble_cnt", bubble_cnt, 0);
        chk("arst_out_pc", out_pc, 0);
        q.delete();
        icnt = 0;
        bcnt = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
